// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the execute-stage multiply/divide
//                unit: MDU opcodes (also used by the decode controller),
//                default operation latencies and small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // MDU opcodes as produced by the decode-stage controller
    localparam logic [3:0] MDU_NONE  = 4'b0000;
    localparam logic [3:0] MDU_MULT  = 4'b0001;
    localparam logic [3:0] MDU_MULTU = 4'b0010;
    localparam logic [3:0] MDU_DIV   = 4'b0011;
    localparam logic [3:0] MDU_DIVU  = 4'b0100;
    localparam logic [3:0] MDU_MFHI  = 4'b0101;
    localparam logic [3:0] MDU_MFLO  = 4'b0110;
    localparam logic [3:0] MDU_MTHI  = 4'b0111;
    localparam logic [3:0] MDU_MTLO  = 4'b1000;

    // Default number of cycles busy stays high per operation class
    localparam int MDU_DEF_MULT_CYCLES = 5;
    localparam int MDU_DEF_DIV_CYCLES  = 10;

    // True for the four multi-cycle arithmetic opcodes
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the two division opcodes
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational 64-bit mult/multu/div/divu result generator.
//                Result layout is {hi, lo}; for division hi holds the
//                remainder and lo the quotient. Flags division by zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Full-width products; operands extended to 64 bits so the low 64 bits
    // of the product are exact for both signed and unsigned forms
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // A single unsigned divider serves both division forms: signed division
    // divides magnitudes and restores signs afterwards. Divisor forced to 1
    // on zero so the divider never sees x/0; the result is discarded anyway.
    assign w_signed_div = (i_op == MDU_DIV);
    assign w_abs_a      = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_abs_b      = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_dividend   = w_signed_div ? w_abs_a : i_a;
    assign w_divisor    = (i_b == 32'd0) ? 32'd1 : (w_signed_div ? w_abs_b : i_b);
    assign w_uquot      = w_dividend / w_divisor;
    assign w_urem       = w_dividend % w_divisor;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    // -2^31 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign w_quot = (w_signed_div && (i_a[31] ^ i_b[31])) ? (~w_uquot + 32'd1) : w_uquot;
    assign w_rem  = (w_signed_div && i_a[31])             ? (~w_urem + 32'd1)  : w_urem;

    // Select the result for the requested operation
    always_comb begin
        o_result      = 64'd0;
        o_div_by_zero = is_div_op(i_op) && (i_b == 32'd0);
        case (i_op)
            MDU_MULT:  o_result = w_prod_s;
            MDU_MULTU: o_result = w_prod_u;
            MDU_DIV,
            MDU_DIVU:  o_result = {w_rem, w_quot};
            default:   o_result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Execute-stage multiply/divide unit. Multi-cycle mult/multu/
//                div/divu into private HI/LO, mthi/mtlo writes, mfhi/mflo
//                reads, and a busy flag for the hazard unit.
//                Build option MDU_ZERO_LATENCY_EN: arithmetic commits at the
//                accept edge and busy is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_hi_tmp;
    logic [31:0] r_lo_tmp;
    logic [3:0]  r_cnt;
    logic        r_busy;

    logic [63:0] w_result;
    logic        w_div_by_zero;
    logic        w_accept;
    logic        w_mt_ok;

    mdu_arith u_arith (
        .i_op          (mdu_op),
        .i_a           (a),
        .i_b           (b),
        .o_result      (w_result),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_accept = start && !req && !r_busy && is_md_op(mdu_op);
    assign w_mt_ok  = !req && !r_busy;

    // Operation FSM, HI/LO state and the completion counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef MDU_ZERO_LATENCY_EN
                        if (!w_div_by_zero) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
`else
                        // Divide by zero shadows the current HI/LO so the
                        // commit at completion leaves them unchanged
                        if (w_div_by_zero) begin
                            r_hi_tmp <= r_hi;
                            r_lo_tmp <= r_lo;
                        end else begin
                            r_hi_tmp <= w_result[63:32];
                            r_lo_tmp <= w_result[31:0];
                        end
                        r_cnt   <= is_div_op(mdu_op) ? c_div_cnt : c_mult_cnt;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
`endif
                    end else if (w_mt_ok && (mdu_op == MDU_MTHI)) begin
                        r_hi <= a;
                    end else if (w_mt_ok && (mdu_op == MDU_MTLO)) begin
                        r_lo <= a;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_hi_tmp;
                        r_lo    <= r_lo_tmp;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Busy exported to the hazard unit
    assign busy = r_busy;

    // Zero-latency read path for mfhi/mflo
    always_comb begin
        out = 32'd0;
        if (mdu_op == MDU_MFHI) begin
            out = r_hi;
        end else if (mdu_op == MDU_MFLO) begin
            out = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the P7 five-stage pipeline. Consumes the `start` and 4-bit MDU opcode produced by the decode-stage controller, plus the forwarded rs/rt operands. Runs multi-cycle mult/multu/div/divu into private HI/LO registers. Services mthi/mtlo writes and mfhi/mflo reads, and exports `busy` so the hazard unit can stall later md/mf/mt instructions in D.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu.
- `clk` input, 1: sole clock. One clock; reset is synchronous and active-high.
- `reset` input, 1: synchronous, active-high.
- `req` input, 1: exception/interrupt request this cycle. Kills the E-stage instruction's MDU side effects.
- `start` input, 1: E-stage instruction is mult/multu/div/divu.
- `mdu_op` input, 4: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo. 0000 and 1001–1111 mean no operation.
- `a` input, 32: rs operand (dividend / multiplicand / mt source).
- `b` input, 32: rt operand (divisor / multiplier).
- `busy` output, 1: operation in flight.
- `out` output, 32: HI for mfhi, LO for mflo, otherwise 0. Combinational.

## Operation
- State: `hi`, `lo`, shadow `hi_tmp`/`lo_tmp`, down-counter `cnt` (4 bits), and `busy`.
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, `cnt` counting).
- IDLE→RUN on an accepted start. A start is accepted when `start`=1, `req`=0, `busy`=0 and `mdu_op` ∈ {0001..0100}.
  - On acceptance, latch the full 64-bit result into `hi_tmp`/`lo_tmp`.
  - Load `cnt` = `MULT_CYCLES` or `DIV_CYCLES`.
- RUN: decrement `cnt` each edge. When `cnt`=1 at an edge, copy `hi_tmp`/`lo_tmp` into `hi`/`lo`, clear `busy`, and return to IDLE.
- Arithmetic rules:
  - mult: signed 32×32→64, {hi,lo}.
  - multu: unsigned 32×32→64, {hi,lo}.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (div/divu with `b`=0): still runs `DIV_CYCLES` with `busy`; `hi`/`lo` are left unchanged at completion.
- mthi/mtlo: write `hi`/`lo` = `a` at the edge, when `req`=0 and `busy`=0. Ignored while `busy`=1.
- Ignored inputs:
  - `start` while busy is ignored (hazard unit guarantees it does not occur).
  - `start` with an mf/mt/invalid op is ignored.
- `req`=1:
  - suppresses acceptance of a new start and of mthi/mtlo that cycle;
  - an operation already in RUN continues and commits normally.
- mfhi/mflo read the architectural `hi`/`lo`. During RUN they return the pre-operation values; stalling is the hazard unit's job.

## Timing
- Reset: `hi`=0, `lo`=0, `hi_tmp`=0, `lo_tmp`=0, `cnt`=0, `busy`=0.
- Reset mid-RUN aborts the operation with no commit.
- Start accepted at edge T0:
  - `busy`=1 from T0 through T0+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - `hi`/`lo` update at edge T0+N; `busy`=0 after that edge.
  - An mfhi at E in the cycle after T0+N sees the new value.
- mthi/mtlo at edge T: `out` reflects the new value from cycle T+1.
- `out` has zero latency from `mdu_op`.

## Configuration
- `MDU_ZERO_LATENCY_EN` defined:
  - accepted mult/div commit directly to `hi`/`lo` at the accept edge;
  - `busy` is tied 0; the parameters are unused.
  - Used for fast functional simulation.
- Not defined: the multi-cycle behaviour above.

## Structure
- Shared package `mdu_pkg` holds:
  - the opcode localparams (`MDU_MULT`..`MDU_MTLO`, `MDU_NONE`=0), shared with the decode controller;
  - the default cycle counts.
- One natural sub-module, `mdu_arith`: combinational 64-bit result from op/`a`/`b`, including the divide-by-zero flag.
- The counter and FSM stay in the top module.

## Test plan
- Post-reset: mfhi → `out`=0, mflo → `out`=0, `busy`=0.
- mult `a`=0xFFFFFFFF, `b`=2:
  - `busy` is high 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFE;
  - multu with the same operands gives hi=0x00000001, lo=0xFFFFFFFE.
- div `a`=0xFFFFFFF9 (−7), `b`=2:
  - `busy` is high 10 cycles;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - divu 7/0 leaves the prior hi/lo unchanged after 10 busy cycles.
- mthi `a`=0x12345678 then mflo/mfhi:
  - hi=0x12345678, lo unchanged;
  - the same mthi with `req`=1 leaves hi unchanged.
- `start` with `req`=1: `busy` stays 0 and hi/lo are unchanged. `req` pulse during RUN: the operation still commits at T0+N.
- Reset asserted at cycle 3 of a div: `busy`=0, hi=lo=0, and no later commit occurs.
